datapath_op_sequencer: RTL and testbench

//  Command sequencer for the 16-bit select-controlled datapath (in/sel -> out).

---
 rtl/datapath_op_sequencer_if.sv | 32 +++
 rtl/datapath_op_sequencer.sv | 127 ++++++++++++
 tb/tb_datapath_op_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_op_sequencer_if.sv
// Command, datapath and result signals of the datapath op sequencer.
// master = sequencer side, slave = command source / datapath / result sink side.
interface datapath_op_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 2
);
    // Handshakes: a beat transfers on the rising edge where valid & ready are both 1;
    // valid and its payload stay stable until that edge, and ready may depend on state only.
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic [SEL_W-1:0] cmd_sel;

    logic [WIDTH-1:0] dp_in;
    logic [SEL_W-1:0] dp_sel;
    logic [WIDTH-1:0] dp_out;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [SEL_W-1:0] res_sel;

    modport master (
        input  cmd_valid, cmd_data, cmd_sel, dp_out, res_ready,
        output cmd_ready, dp_in, dp_sel, res_valid, res_data, res_sel
    );

    modport slave (
        output cmd_valid, cmd_data, cmd_sel, dp_out, res_ready,
        input  cmd_ready, dp_in, dp_sel, res_valid, res_data, res_sel
    );
endinterface

// File: rtl/datapath_op_sequencer.sv
// Queues (data, sel) commands, issues them one at a time to the datapath,
// waits SETTLE cycles and returns the captured datapath result.
module datapath_op_sequencer #(
    parameter int WIDTH  = 16,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    datapath_op_sequencer_if.master    bus,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy,
    output logic [1:0]                 state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(SETTLE) + 1;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [SEL_W-1:0] sel_mem  [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CNT_W-1:0] settle_q;
    logic [WIDTH-1:0] dp_in_q, res_data_q;
    logic [SEL_W-1:0] dp_sel_q, res_sel_q;
    logic             res_valid_q;
    logic             cmd_ready_w, push, pop, capture;

    assign cmd_ready_w   = (count_q < CW'(DEPTH)) & ~flush;
    assign push          = bus.cmd_valid & cmd_ready_w;
    assign bus.cmd_ready = cmd_ready_w;
    assign bus.dp_in     = dp_in_q;
    assign bus.dp_sel    = dp_sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_sel   = res_sel_q;
    assign fifo_count    = count_q;
    assign busy          = (state_q != IDLE) | (count_q != '0);
    assign state         = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: if (count_q != '0) begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (settle_q == '0) begin
                capture = 1'b1;
                state_d = RESULT;
            end
            RESULT: if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // flush overrides everything the FSM wanted to do this edge
        if (flush) begin
            state_d = IDLE;
            pop     = 1'b0;
            capture = 1'b0;
        end
    end

    // Storage only; emptiness is tracked by count_q, so no reset is needed here.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr] <= bus.cmd_data;
            sel_mem[wr_ptr]  <= bus.cmd_sel;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            settle_q    <= '0;
            dp_in_q     <= '0;
            dp_sel_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                dp_in_q  <= data_mem[rd_ptr];
                dp_sel_q <= sel_mem[rd_ptr];
                settle_q <= CNT_W'(SETTLE - 1);
            end else if (state_q == WAIT && !capture) begin
                settle_q <= settle_q - CNT_W'(1);
            end
            if (capture) begin
                res_data_q  <= bus.dp_out;
                res_sel_q   <= dp_sel_q;
                res_valid_q <= 1'b1;
            end else if (state_q == RESULT && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_datapath_op_sequencer.sv
// Bench for datapath_op_sequencer: directed scenarios plus random traffic,
// with a queue scoreboard fed on command acceptance and drained by a result monitor.
module tb_datapath_op_sequencer;
    localparam int WIDTH  = 16;
    localparam int SEL_W  = 2;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] fifo_count;
    logic       busy;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;
    logic [SEL_W+WIDTH-1:0] exp_q[$];

    datapath_op_sequencer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus();

    datapath_op_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clock(clk), .reset(rst_n), .flush(flush), .bus(bus.master),
        .fifo_count(fifo_count), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    // Stand-in datapath: a distinct transform per select value.
    function automatic logic [WIDTH-1:0] dp_func(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s);
        case (s)
            2'd0:    return d + 16'd1;
            2'd1:    return d ^ 16'hA5A5;
            2'd2:    return {d[14:0], d[15]};
            default: return ~d;
        endcase
    endfunction

    assign bus.dp_out = dp_func(bus.dp_in, bus.dp_sel);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s);
        logic acc;
        int   n;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_sel   = s;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            #1;
            acc = bus.cmd_ready;
            tick();
            n++;
        end
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("drain_done", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: retire results against the scoreboard, then record accepted commands.
    always @(negedge clk) begin
        logic [SEL_W+WIDTH-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(bus.res_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", 32'(bus.res_data), 32'(e[WIDTH-1:0]));
                    check("res_sel", 32'(bus.res_sel), 32'(e[SEL_W+WIDTH-1:WIDTH]));
                end
            end
            if (flush) exp_q.delete();
            else if (bus.cmd_valid && bus.cmd_ready)
                exp_q.push_back({bus.cmd_sel, dp_func(bus.cmd_data, bus.cmd_sel)});
        end
    end

    initial begin
        logic [WIDTH-1:0] rd;
        logic [SEL_W-1:0] rs;
        logic             acc;
        int               n;

        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_sel   = '0;
        bus.res_ready = 1'b0;

        // 1: reset held with random inputs
        #1 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_data  = 16'($urandom);
            bus.cmd_sel   = 2'($urandom_range(0, 3));
            bus.res_ready = 1'($urandom_range(0, 1));
            tick();
            check("rst_res_valid", 32'(bus.res_valid), 32'd0);
            check("rst_dp_in", 32'(bus.dp_in), 32'd0);
            check("rst_fifo_count", 32'(fifo_count), 32'd0);
            check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
        end
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_sel", 32'(bus.res_sel), 32'd0);
        check("rst_dp_sel", 32'(bus.dp_sel), 32'd0);
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_state", 32'(state), 32'd0);

        // 2: single command latency
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 16'd50;
        bus.cmd_sel   = 2'd2;
        #1 check("t2_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("t2_dp_in", 32'(bus.dp_in), 32'd50);
        check("t2_dp_sel", 32'(bus.dp_sel), 32'd2);
        check("t2_state_wait", 32'(state), 32'd1);
        check("t2_res_valid_k1", 32'(bus.res_valid), 32'd0);
        tick();
        check("t2_res_valid_k2", 32'(bus.res_valid), 32'd0);
        tick();
        check("t2_res_valid_k3", 32'(bus.res_valid), 32'd1);
        check("t2_res_data", 32'(bus.res_data), 32'(dp_func(16'd50, 2'd2)));
        check("t2_res_sel", 32'(bus.res_sel), 32'd2);
        tick();
        check("t2_res_valid_k4", 32'(bus.res_valid), 32'd0);

        // 3 + 4: fill the FIFO with the result stalled, then hold
        bus.res_ready = 1'b0;
        send_cmd(16'd40, 2'd3);
        send_cmd(16'd10, 2'd0);
        send_cmd(16'd20, 2'd1);
        send_cmd(16'd50, 2'd2);
        send_cmd(16'd7,  2'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 16'd9;
        bus.cmd_sel   = 2'd0;
        #1;
        check("t3_cmd_ready_full", 32'(bus.cmd_ready), 32'd0);
        check("t3_fifo_full", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_res_valid", 32'(bus.res_valid), 32'd1);
            check("t4_res_data", 32'(bus.res_data), 32'(dp_func(16'd40, 2'd3)));
            check("t4_res_sel", 32'(bus.res_sel), 32'd3);
            check("t4_dp_in", 32'(bus.dp_in), 32'd40);
            check("t4_dp_sel", 32'(bus.dp_sel), 32'd3);
            check("t4_fifo_count", 32'(fifo_count), 32'd4);
        end
        bus.res_ready = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            #1;
            acc = bus.cmd_ready;
            tick();
            n++;
        end
        check("t3_sixth_accepted", 32'(acc), 32'd1);
        bus.cmd_valid = 1'b0;
        drain();

        // 5: flush in WAIT with three queued and a command offered
        bus.res_ready = 1'b0;
        send_cmd(16'h1111, 2'd0);
        send_cmd(16'h2222, 2'd1);
        send_cmd(16'h3333, 2'd2);
        send_cmd(16'h4444, 2'd3);
        bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 16'h5555;
        bus.cmd_sel   = 2'd1;
        tick();
        bus.res_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        tick();
        check("t5_pre_state", 32'(state), 32'd1);
        check("t5_pre_count", 32'(fifo_count), 32'd3);
        flush = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 16'h6666;
        #1 check("t5_cmd_ready_flush", 32'(bus.cmd_ready), 32'd0);
        tick();
        flush = 1'b0;
        bus.cmd_valid = 1'b0;
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_state", 32'(state), 32'd0);
        check("t5_res_valid", 32'(bus.res_valid), 32'd0);
        check("t5_dp_in_kept", 32'(bus.dp_in), 32'h2222);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_no_result", 32'(bus.res_valid), 32'd0);
            check("t5_busy", 32'(busy), 32'd0);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_data  = 16'($urandom);
            bus.cmd_sel   = 2'($urandom_range(0, 3));
            bus.res_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();

        // 6: asynchronous reset in the middle of WAIT
        rd = 16'($urandom_range(1, 65535));
        rs = 2'($urandom_range(0, 3));
        send_cmd(rd, rs);
        tick();
        check("t6_in_wait", 32'(state), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_dp_in", 32'(bus.dp_in), 32'd0);
        check("t6_dp_sel", 32'(bus.dp_sel), 32'd0);
        check("t6_state", 32'(state), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_res_valid", 32'(bus.res_valid), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6_no_result", 32'(bus.res_valid), 32'd0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
